mm_job_scheduler: RTL and testbench
===================================

Name: mm_job_scheduler

Overview:
Multi-requester job scheduler in front of the matrix-multiplier top. Accepts job descriptors (opaque config words) from NREQ requesters over valid/ready and arbitrates round-robin. Sequences the multiplier's level-sensitive start: raise, hold until done, drop, enforce a low gap. Returns a completion tagged with the requester ID.

Parameters:
NREQ, 4, number of requesters (>=2)
CFG_W, 32, width of job config word forwarded to the multiplier
GAP_CYC, 2, minimum cycles start held low between jobs (>=2, covers the multiplier's 2-flop start edge detector)
TIMEOUT, 1024, watchdog limit in cycles (used only with optional feature)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active high
req_valid_i  in  NREQ  per-requester job valid
req_ready_o  out  NREQ  per-requester accept, at most one bit set
req_cfg_i  in  NREQ*CFG_W  per-requester config, requester k at bits [k*CFG_W +: CFG_W]
mm_start_o  out  1  multiplier start level
mm_cfg_o  out  CFG_W  config of the active job
mm_done_i  in  1  multiplier done, level-sampled
cpl_valid_o  out  1  completion valid
cpl_id_o  out  $clog2(NREQ)  requester ID of the completed job
cpl_err_o  out  1  completion aborted by watchdog
cpl_ready_i  in  1  completion accept
busy_o  out  1  high in any state except IDLE

Behaviour:
- Single clock and single reset. Reset is synchronous and active-high. State goes to IDLE.
- Reset values: all outputs 0. RR pointer = NREQ-1, so requester 0 has top priority after reset. Gap counter = 0.
- States are IDLE, RUN, CPL and GAP.
- IDLE: the winner is the first set req_valid_i bit, searching upward from pointer+1 and wrapping. req_ready_o[winner] is combinational, in the same cycle as valid.
- On accept (valid & ready at an edge):
  - capture cfg into mm_cfg_o and the ID;
  - update pointer = winner;
  - go to RUN, so mm_start_o = 1 from the next cycle.
- RUN: mm_start_o = 1 and mm_cfg_o stable. mm_done_i is sampled in every RUN cycle. On done = 1, go to CPL at the next edge: mm_start_o = 0 and cpl_valid_o = 1.
- CPL: hold cpl_valid_o, cpl_id_o and cpl_err_o stable until cpl_ready_i = 1. Then go to GAP and clear cpl_valid_o.
- GAP: mm_start_o = 0. The counter counts cycles in which mm_done_i = 0. Return to IDLE after GAP_CYC such consecutive cycles; the count restarts if done is seen high.
- req_ready_o is 0 in every state except IDLE, so no job is accepted while one is in flight or unacknowledged.
- mm_done_i is ignored outside RUN. Done stuck high after a job therefore delays the next start and cannot complete it early.
- mm_cfg_o holds its value through CPL and GAP. It is cleared only by reset.
- A requester whose valid drops before grant loses nothing: there is no state per requester.
- Reset mid-operation:
  - everything returns to IDLE;
  - mm_start_o falls at the next edge;
  - an in-flight job is dropped with no completion.
- Minimum job turnaround is 1 (accept) + RUN length + 1 (CPL with ready = 1) + GAP_CYC cycles.

Optional Feature:
MM_SCHED_WATCHDOG_EN
- Defined: a counter is cleared on entry to RUN and increments each RUN cycle. If it reaches TIMEOUT with no done, go to CPL with cpl_err_o = 1 and mm_start_o dropped. cpl_err_o = 0 for a normal done. Done and timeout in the same cycle count as a normal done.
- Undefined: no counter, cpl_err_o tied 0, RUN waits for done indefinitely.

Decomposition:
- Package mm_sched_pkg holds:
  - the state enum (IDLE/RUN/CPL/GAP);
  - the completion struct {id, err};
  - the localparam ID_W = $clog2(NREQ).
- One sub-module, mm_rr_arbiter: a combinational round-robin pick given the valid vector and pointer. It outputs a one-hot grant and a binary ID.

Test Plan:
- Req0 valid with cfg 0xA5A50001 at cycle 0:
  - req_ready_o = 4'b0001 in cycle 0;
  - mm_start_o = 1 and mm_cfg_o = 0xA5A50001 from cycle 1;
  - mm_done_i pulse at cycle 10 gives start = 0 and cpl_valid_o = 1 with id 0 at cycle 11;
  - with cpl_ready_i = 1, IDLE is reached at cycle 14 (GAP_CYC = 2).
- All four req_valid_i held high, cpl_ready_i = 1 → grant order 0, 1, 2, 3, 0. cpl_id_o follows the same order.
- cpl_ready_i held 0 for 5 cycles after done:
  - cpl_valid_o and cpl_id_o stay stable;
  - req_ready_o = 0 and mm_start_o = 0 throughout;
  - the next grant comes only after the accept plus the gap.
- mm_done_i stuck high for 6 cycles after completion → GAP does not exit until 2 cycles after done falls, and no start is raised earlier.
- rst_i pulsed during RUN:
  - next cycle all outputs are 0 and no completion is issued;
  - afterwards req1 and req3 are valid, and req1 is granted first.
- With MM_SCHED_WATCHDOG_EN, TIMEOUT = 16 and no done → after 16 RUN cycles, cpl_valid_o = 1, cpl_err_o = 1 and start = 0. Without the macro, start stays high.

Source files
------------

// File: rtl/mm_sched_pkg.sv
// Shared types for the matrix-multiplier job scheduler: FSM states,
// completion payload and the requester ID width.
package mm_sched_pkg;

    localparam int unsigned NREQ_DFLT = 4;
    localparam int unsigned ID_W      = $clog2(NREQ_DFLT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CPL  = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_e;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic            err;
    } cpl_t;

endpackage

// File: rtl/mm_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from
// ptr+1 with wrap-around. Produces a one-hot grant and its binary index.
module mm_rr_arbiter
    import mm_sched_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DFLT
)(
    input  logic [NREQ-1:0] req_valid,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id
);

    // Walk the NREQ candidates after ptr, keep the first valid one
    always_comb begin
        logic [ID_W:0] idx;
        logic          found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (ID_W+1)'(ptr) + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NREQ)) begin
                idx = idx - (ID_W+1)'(NREQ);
            end
            if (!found && req_valid[idx[ID_W-1:0]]) begin
                found                   = 1'b1;
                grant[idx[ID_W-1:0]]    = 1'b1;
                grant_id                = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mm_job_scheduler.sv
// Round-robin job scheduler in front of the matrix multiplier. Accepts one
// job at a time, holds the multiplier's level start until done, returns a
// tagged completion, then keeps start low for GAP_CYC done-free cycles.
// Optional watchdog: define MM_SCHED_WATCHDOG_EN to abort a RUN that sees
// no done within TIMEOUT cycles (completion flagged with cpl_err_o).
// The requester ID width comes from the package, so NREQ must equal NREQ_DFLT.
module mm_job_scheduler
    import mm_sched_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DFLT,
    parameter int unsigned CFG_W   = 32,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TIMEOUT = 1024
)(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [NREQ*CFG_W-1:0]   req_cfg_i,
    output logic                    mm_start_o,
    output logic [CFG_W-1:0]        mm_cfg_o,
    input  logic                    mm_done_i,
    output logic                    cpl_valid_o,
    output logic [$clog2(NREQ)-1:0] cpl_id_o,
    output logic                    cpl_err_o,
    input  logic                    cpl_ready_i,
    output logic                    busy_o
);

    localparam int unsigned GAP_W = $clog2(GAP_CYC);

    if (NREQ != NREQ_DFLT || NREQ < 2 || GAP_CYC < 2 || TIMEOUT < 2) begin : g_param_check
        $error("mm_job_scheduler: unsupported parameter set");
    end

    sched_state_e     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  job_id;
    logic [GAP_W-1:0] gap_cnt;
    cpl_t             cpl_q;

    logic [NREQ-1:0]  grant_c;
    logic [ID_W-1:0]  win_id_c;
    logic             wd_hit_c;
    logic             run_exit_c;
    logic             run_err_c;

    logic [CFG_W-1:0] cfg_arr [NREQ];

    // Split the flat config bus into per-requester words
    for (genvar k = 0; k < NREQ; k++) begin : g_cfg
        assign cfg_arr[k] = req_cfg_i[k*CFG_W +: CFG_W];
    end

    mm_rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_valid (req_valid_i),
        .ptr       (rr_ptr),
        .grant     (grant_c),
        .grant_id  (win_id_c)
    );

    // Ready only while idle; grant is already qualified by valid
    assign req_ready_o = (state == ST_IDLE) ? grant_c : '0;

`ifdef MM_SCHED_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT);

    logic [WD_W-1:0] wd_cnt;

    // Count RUN cycles; held at zero in every other state
    always_ff @(posedge clk_i) begin
        if (rst_i || state != ST_RUN) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_hit_c = (state == ST_RUN) && (wd_cnt == WD_W'(TIMEOUT - 1));
`else
    assign wd_hit_c = 1'b0;
`endif

    // A simultaneous done wins over the watchdog
    assign run_exit_c = mm_done_i | wd_hit_c;
    assign run_err_c  = ~mm_done_i & wd_hit_c;

    assign cpl_id_o  = cpl_q.id;
    assign cpl_err_o = cpl_q.err;

    // Scheduler FSM with registered start/cfg/completion/busy outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            rr_ptr      <= ID_W'(NREQ - 1);
            job_id      <= '0;
            gap_cnt     <= '0;
            cpl_q       <= '0;
            mm_start_o  <= 1'b0;
            mm_cfg_o    <= '0;
            cpl_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req_valid_i) begin
                        mm_cfg_o   <= cfg_arr[win_id_c];
                        job_id     <= win_id_c;
                        rr_ptr     <= win_id_c;
                        mm_start_o <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (run_exit_c) begin
                        mm_start_o  <= 1'b0;
                        cpl_valid_o <= 1'b1;
                        cpl_q.id    <= job_id;
                        cpl_q.err   <= run_err_c;
                        state       <= ST_CPL;
                    end
                end
                ST_CPL: begin
                    if (cpl_ready_i) begin
                        cpl_valid_o <= 1'b0;
                        gap_cnt     <= '0;
                        state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (mm_done_i) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        gap_cnt <= '0;
                        busy_o  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mm_job_scheduler.sv
// Directed bench for mm_job_scheduler: a cycle table for the basic job flow,
// then hand sequences for round-robin order, completion back-pressure,
// stuck done during the gap, reset mid-run and the RUN watchdog.
module tb_mm_job_scheduler;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned CFG_W = 32;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*CFG_W-1:0] req_cfg;
    logic                  mm_start;
    logic [CFG_W-1:0]      mm_cfg;
    logic                  mm_done;
    logic                  cpl_valid;
    logic [1:0]            cpl_id;
    logic                  cpl_err;
    logic                  cpl_ready;
    logic                  busy;

    int n_checks = 0;
    int n_errors = 0;

    mm_job_scheduler #(
        .NREQ    (NREQ),
        .CFG_W   (CFG_W),
        .GAP_CYC (2),
        .TIMEOUT (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_cfg_i   (req_cfg),
        .mm_start_o  (mm_start),
        .mm_cfg_o    (mm_cfg),
        .mm_done_i   (mm_done),
        .cpl_valid_o (cpl_valid),
        .cpl_id_o    (cpl_id),
        .cpl_err_o   (cpl_err),
        .cpl_ready_i (cpl_ready),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        done;
        logic        crdy;
        int          rep;
        logic [3:0]  e_ready;
        logic        e_start;
        logic [31:0] e_cfg;
        logic        e_cv;
        logic [1:0]  e_id;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] cfg_of(input int k);
        return 32'hA5A5_0001 + 32'(k);
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic d, input logic cr, input int rep,
                                input logic [3:0] er, input logic es, input logic [31:0] ec,
                                input logic ecv, input logic [1:0] eid, input logic eb);
        vec_t r;
        r.rst = 1'b0; r.valid = v; r.done = d; r.crdy = cr; r.rep = rep;
        r.e_ready = er; r.e_start = es; r.e_cfg = ec; r.e_cv = ecv; r.e_id = eid; r.e_busy = eb;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after the falling edge, then settle before sampling
    task automatic drive(input logic r, input logic [3:0] v, input logic d, input logic cr);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        mm_done   = d;
        cpl_ready = cr;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] oh;
        rst       = 1'b1;
        req_valid = '0;
        mm_done   = 1'b0;
        cpl_ready = 1'b0;
        req_cfg   = {cfg_of(3), cfg_of(2), cfg_of(1), cfg_of(0)};

        drive(1'b1, 4'b0000, 1'b0, 1'b0);
        drive(1'b1, 4'b0000, 1'b0, 1'b0);

        // Basic job on req0, done at cycle 10, then a stalled job on req1
        tbl.push_back(mk(4'b0000, 0, 0, 1, 4'b0000, 0, 32'h0,       0, 0, 0));
        tbl.push_back(mk(4'b0001, 0, 0, 1, 4'b0001, 0, 32'h0,       0, 0, 0));
        tbl.push_back(mk(4'b0000, 0, 0, 9, 4'b0000, 1, cfg_of(0),   0, 0, 1));
        tbl.push_back(mk(4'b0000, 1, 0, 1, 4'b0000, 1, cfg_of(0),   0, 0, 1));
        tbl.push_back(mk(4'b0000, 0, 1, 1, 4'b0000, 0, cfg_of(0),   1, 0, 1));
        tbl.push_back(mk(4'b0010, 0, 0, 2, 4'b0000, 0, cfg_of(0),   0, 0, 1));
        tbl.push_back(mk(4'b0010, 0, 0, 1, 4'b0010, 0, cfg_of(0),   0, 0, 0));
        tbl.push_back(mk(4'b0000, 1, 0, 1, 4'b0000, 1, cfg_of(1),   0, 0, 1));
        tbl.push_back(mk(4'b0000, 0, 0, 2, 4'b0000, 0, cfg_of(1),   1, 1, 1));
        tbl.push_back(mk(4'b0000, 0, 1, 1, 4'b0000, 0, cfg_of(1),   1, 1, 1));
        tbl.push_back(mk(4'b0000, 0, 0, 2, 4'b0000, 0, cfg_of(1),   0, 0, 1));
        tbl.push_back(mk(4'b0000, 0, 0, 1, 4'b0000, 0, cfg_of(1),   0, 0, 0));

        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].rep; r++) begin
                drive(tbl[i].rst, tbl[i].valid, tbl[i].done, tbl[i].crdy);
                check($sformatf("tbl%0d.%0d ready", i, r), 32'(req_ready), 32'(tbl[i].e_ready));
                check($sformatf("tbl%0d.%0d start", i, r), 32'(mm_start), 32'(tbl[i].e_start));
                check($sformatf("tbl%0d.%0d cfg", i, r), mm_cfg, tbl[i].e_cfg);
                check($sformatf("tbl%0d.%0d cpl_valid", i, r), 32'(cpl_valid), 32'(tbl[i].e_cv));
                if (tbl[i].e_cv) begin
                    check($sformatf("tbl%0d.%0d cpl_id", i, r), 32'(cpl_id), 32'(tbl[i].e_id));
                    check($sformatf("tbl%0d.%0d cpl_err", i, r), 32'(cpl_err), 32'h0);
                end
                check($sformatf("tbl%0d.%0d busy", i, r), 32'(busy), 32'(tbl[i].e_busy));
            end
        end

        // Round-robin with all requesters valid: 0,1,2,3,0
        drive(1'b1, 4'b0000, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            drive(1'b0, 4'b1111, 1'b0, 1'b1);
            check($sformatf("rr%0d grant", k), 32'(req_ready), 32'(oh));
            drive(1'b0, 4'b1111, 1'b0, 1'b1);
            check($sformatf("rr%0d start", k), 32'(mm_start), 32'h1);
            check($sformatf("rr%0d cfg", k), mm_cfg, cfg_of(k % 4));
            check($sformatf("rr%0d ready_run", k), 32'(req_ready), 32'h0);
            drive(1'b0, 4'b1111, 1'b1, 1'b1);
            drive(1'b0, 4'b1111, 1'b0, 1'b1);
            check($sformatf("rr%0d cpl_valid", k), 32'(cpl_valid), 32'h1);
            check($sformatf("rr%0d cpl_id", k), 32'(cpl_id), 32'(k % 4));
            check($sformatf("rr%0d start_cpl", k), 32'(mm_start), 32'h0);
            drive(1'b0, 4'b1111, 1'b0, 1'b1);
            drive(1'b0, 4'b1111, 1'b0, 1'b1);
            check($sformatf("rr%0d ready_gap", k), 32'(req_ready), 32'h0);
        end

        // Completion back-pressure for 5 cycles on a req2 job
        drive(1'b0, 4'b0100, 1'b0, 1'b0);
        check("stall grant2", 32'(req_ready), 32'b0100);
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
        check("stall cfg2", mm_cfg, cfg_of(2));
        drive(1'b0, 4'b0000, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b1111, 1'b0, 1'b0);
            check($sformatf("stall%0d cpl_valid", c), 32'(cpl_valid), 32'h1);
            check($sformatf("stall%0d cpl_id", c), 32'(cpl_id), 32'h2);
            check($sformatf("stall%0d ready", c), 32'(req_ready), 32'h0);
            check($sformatf("stall%0d start", c), 32'(mm_start), 32'h0);
        end
        drive(1'b0, 4'b1111, 1'b0, 1'b1);
        check("stall accept cpl_valid", 32'(cpl_valid), 32'h1);
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'b1111, 1'b0, 1'b0);
            check($sformatf("stall gap%0d cpl_valid", c), 32'(cpl_valid), 32'h0);
            check($sformatf("stall gap%0d ready", c), 32'(req_ready), 32'h0);
            check($sformatf("stall gap%0d busy", c), 32'(busy), 32'h1);
        end
        drive(1'b0, 4'b1111, 1'b0, 1'b0);
        check("stall next grant3", 32'(req_ready), 32'b1000);

        // Done stuck high for 6 cycles after the req3 job completes
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        check("stuck run start", 32'(mm_start), 32'h1);
        drive(1'b0, 4'b0000, 1'b1, 1'b1);
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 4'b1111, 1'b1, 1'b1);
            if (c == 0) begin
                check("stuck cpl_id", 32'(cpl_id), 32'h3);
                check("stuck cpl_valid", 32'(cpl_valid), 32'h1);
            end
            check($sformatf("stuck%0d ready", c), 32'(req_ready), 32'h0);
            check($sformatf("stuck%0d start", c), 32'(mm_start), 32'h0);
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'b1111, 1'b0, 1'b1);
            check($sformatf("stuck fall%0d ready", c), 32'(req_ready), 32'h0);
            check($sformatf("stuck fall%0d busy", c), 32'(busy), 32'h1);
        end
        drive(1'b0, 4'b1111, 1'b0, 1'b1);
        check("stuck release grant0", 32'(req_ready), 32'b0001);
        check("stuck release busy", 32'(busy), 32'h0);

        // Reset while RUN: everything clears, pointer back to NREQ-1
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        check("rst run start", 32'(mm_start), 32'h1);
        drive(1'b1, 4'b0000, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 1'b0, 1'b1);
        check("rst start", 32'(mm_start), 32'h0);
        check("rst cfg", mm_cfg, 32'h0);
        check("rst cpl_valid", 32'(cpl_valid), 32'h0);
        check("rst cpl_id", 32'(cpl_id), 32'h0);
        check("rst cpl_err", 32'(cpl_err), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        drive(1'b0, 4'b1010, 1'b0, 1'b1);
        check("rst grant1", 32'(req_ready), 32'b0010);
        check("rst no cpl", 32'(cpl_valid), 32'h0);

        // RUN with no done: watchdog fires after 16 cycles only if enabled
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, 4'b0000, 1'b0, 1'b0);
            check($sformatf("wd run%0d start", c), 32'(mm_start), 32'h1);
            check($sformatf("wd run%0d cpl_valid", c), 32'(cpl_valid), 32'h0);
        end
        drive(1'b0, 4'b0000, 1'b0, 1'b0);
`ifdef MM_SCHED_WATCHDOG_EN
        check("wd cpl_valid", 32'(cpl_valid), 32'h1);
        check("wd cpl_err", 32'(cpl_err), 32'h1);
        check("wd cpl_id", 32'(cpl_id), 32'h1);
        check("wd start", 32'(mm_start), 32'h0);
`else
        check("nowd start", 32'(mm_start), 32'h1);
        check("nowd cpl_valid", 32'(cpl_valid), 32'h0);
        for (int c = 0; c < 30; c++) begin
            drive(1'b0, 4'b0000, 1'b0, 1'b0);
        end
        check("nowd long start", 32'(mm_start), 32'h1);
        check("nowd long cpl_err", 32'(cpl_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
